// File: rtl/clock_lock_sequencer.sv
// Pixel-clock lock qualifier: synchronises the raw PLL/MMCM lock, holds it for LOCK_HOLD cycles,
// then releases NUM_RESETS domain resets in staggered order and reports a qualified lock.
module clock_lock_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_HOLD   = 16,
  parameter int unsigned NUM_RESETS  = 3,
  parameter int unsigned RST_STAGGER = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clk_pix,
  input  logic                  rst,
  input  logic                  locked_in,
  input  logic                  sw_restart,
  output logic [NUM_RESETS-1:0] rst_out,
  output logic                  clk_pix_locked,
  output logic [CNT_W-1:0]      loss_count,
  output logic [1:0]            state
);

  localparam int unsigned HoldW = $clog2(LOCK_HOLD + 1);
  localparam int unsigned StagW = (RST_STAGGER > 1) ? $clog2(RST_STAGGER) : 1;
  localparam int unsigned IdxW  = $clog2(NUM_RESETS + 1);

  localparam logic [HoldW-1:0] HoldMax = HoldW'(LOCK_HOLD);
  localparam logic [StagW-1:0] StagMax = StagW'(RST_STAGGER - 1);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(NUM_RESETS - 1);

  typedef enum logic [1:0] {
    StWaitLock = 2'd0,
    StHold     = 2'd1,
    StRelease  = 2'd2,
    StRun      = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_e                 state_q;
  logic [HoldW-1:0]       hold_cnt_q;
  logic [StagW-1:0]       stag_cnt_q;
  logic [IdxW-1:0]        idx_q;
  logic [NUM_RESETS-1:0]  rst_out_q;
  logic                   locked_q;
  logic [CNT_W-1:0]       loss_q;

  // locked_in is asynchronous to clk_pix; only the last stage is ever looked at
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state_q    <= StWaitLock;
      hold_cnt_q <= '0;
      stag_cnt_q <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      locked_q   <= 1'b0;
      loss_q     <= '0;
    end else begin
      unique case (state_q)
        StWaitLock: begin
          if (lock_s) begin
            state_q    <= StHold;
            hold_cnt_q <= HoldW'(1);
          end
        end

        StHold: begin
          // Losing lock before any release is not a counted loss
          if (!lock_s || sw_restart) begin
            state_q    <= StWaitLock;
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HoldMax) begin
            hold_cnt_q   <= '0;
            rst_out_q[0] <= 1'b0;
            stag_cnt_q   <= '0;
            idx_q        <= IdxW'(1);
            if (NUM_RESETS == 1) begin
              state_q  <= StRun;
              locked_q <= 1'b1;
            end else begin
              state_q <= StRelease;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end

        StRelease, StRun: begin
          if (!lock_s || sw_restart) begin
            // A real lock drop wins over a simultaneous software restart
            if (!lock_s && (loss_q != '1)) begin
              loss_q <= loss_q + 1'b1;
            end
            state_q    <= StWaitLock;
            rst_out_q  <= '1;
            locked_q   <= 1'b0;
            hold_cnt_q <= '0;
            stag_cnt_q <= '0;
            idx_q      <= '0;
          end else if (state_q == StRelease) begin
            if (stag_cnt_q == StagMax) begin
              for (int i = 0; i < NUM_RESETS; i++) begin
                if (idx_q == IdxW'(i)) begin
                  rst_out_q[i] <= 1'b0;
                end
              end
              stag_cnt_q <= '0;
              idx_q      <= idx_q + 1'b1;
              if (idx_q == IdxLast) begin
                state_q  <= StRun;
                locked_q <= 1'b1;
              end
            end else begin
              stag_cnt_q <= stag_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign rst_out        = rst_out_q;
  assign clk_pix_locked = locked_q;
  assign loss_count     = loss_q;
  assign state          = state_q;

endmodule

// File: tb/tb_clock_lock_sequencer.sv
// Bench for clock_lock_sequencer: timeline model checked every cycle plus directed literal checks.
// Two instances share stimulus; the second uses a 2-bit loss counter to exercise saturation.
module tb_clock_lock_sequencer;

  localparam int unsigned SYNC     = 2;
  localparam int unsigned HOLD     = 16;
  localparam int unsigned NR       = 3;
  localparam int unsigned STAG     = 4;
  localparam int unsigned RUN_K    = HOLD + (NR - 1) * STAG;
  localparam int unsigned REL_EDGE = SYNC + HOLD;

  logic       clk_pix = 1'b0;
  logic       rst;
  logic       locked_in;
  logic       sw_restart;
  logic [2:0] rst_out,  rst_out_s;
  logic       lk,       lk_s;
  logic [7:0] loss;
  logic [1:0] loss_s;
  logic [1:0] st,       st_s;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  always #5 clk_pix = ~clk_pix;

  clock_lock_sequencer #(
    .SYNC_STAGES(SYNC),
    .LOCK_HOLD  (HOLD),
    .NUM_RESETS (NR),
    .RST_STAGGER(STAG),
    .CNT_W      (8)
  ) dut (
    .clk_pix       (clk_pix),
    .rst           (rst),
    .locked_in     (locked_in),
    .sw_restart    (sw_restart),
    .rst_out       (rst_out),
    .clk_pix_locked(lk),
    .loss_count    (loss),
    .state         (st)
  );

  clock_lock_sequencer #(
    .SYNC_STAGES(SYNC),
    .LOCK_HOLD  (HOLD),
    .NUM_RESETS (NR),
    .RST_STAGGER(STAG),
    .CNT_W      (2)
  ) dut_sat (
    .clk_pix       (clk_pix),
    .rst           (rst),
    .locked_in     (locked_in),
    .sw_restart    (sw_restart),
    .rst_out       (rst_out_s),
    .clk_pix_locked(lk_s),
    .loss_count    (loss_s),
    .state         (st_s)
  );

  // Model: s is locked_in delayed SYNC edges; m_k counts edges since qualification began.
  logic        m_hist[$];
  bit          m_active;
  int unsigned m_k;
  int unsigned m_loss;
  int unsigned m_loss_s;

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    m_active = 1'b0;
    m_k      = 0;
    m_loss   = 0;
    m_loss_s = 0;
  endfunction

  function automatic void model_step();
    logic s;
    if (rst) begin
      model_reset();
      return;
    end
    s = m_hist.pop_front();
    m_hist.push_back(locked_in);
    if (!m_active) begin
      if (s) begin
        m_active = 1'b1;
        m_k      = 0;
      end
    end else if (!s || sw_restart) begin
      if (!s && m_k >= HOLD) begin
        if (m_loss < 255) m_loss++;
        if (m_loss_s < 3) m_loss_s++;
      end
      m_active = 1'b0;
      m_k      = 0;
    end else if (m_k < 100000) begin
      m_k++;
    end
  endfunction

  function automatic logic [2:0] exp_rst_out();
    logic [2:0] r;
    for (int i = 0; i < NR; i++) r[i] = !(m_active && m_k >= HOLD + i * STAG);
    return r;
  endfunction

  function automatic logic exp_locked();
    return m_active && m_k >= RUN_K;
  endfunction

  function automatic logic [1:0] exp_state();
    if (!m_active) return 2'd0;
    if (m_k < HOLD) return 2'd1;
    if (m_k < RUN_K) return 2'd2;
    return 2'd3;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic void compare_all();
    check("cyc.rst_out",     32'(rst_out),   32'(exp_rst_out()));
    check("cyc.locked",      32'(lk),        32'(exp_locked()));
    check("cyc.loss",        32'(loss),      m_loss);
    check("cyc.state",       32'(st),        32'(exp_state()));
    check("cyc.sat_rst_out", 32'(rst_out_s), 32'(exp_rst_out()));
    check("cyc.sat_locked",  32'(lk_s),      32'(exp_locked()));
    check("cyc.sat_loss",    32'(loss_s),    m_loss_s);
    check("cyc.sat_state",   32'(st_s),      32'(exp_state()));
  endfunction

  initial forever begin
    @(posedge clk_pix);
    model_step();
  end

  initial forever begin
    @(negedge clk_pix);
    if (check_en) compare_all();
  end

  // From WAIT with s=0: raise lock; the next edge is sampling edge 0.
  task automatic release_seq(string tag);
    @(negedge clk_pix);
    locked_in = 1'b1;
    repeat (REL_EDGE) @(negedge clk_pix);
    check({tag, ".e17_rst_out"}, 32'(rst_out), 32'd7);
    check({tag, ".e17_state"},   32'(st),      32'd1);
    @(negedge clk_pix);
    check({tag, ".e18_rst_out"}, 32'(rst_out), 32'd6);
    check({tag, ".e18_state"},   32'(st),      32'd2);
    repeat (3) @(negedge clk_pix);
    check({tag, ".e21_rst_out"}, 32'(rst_out), 32'd6);
    @(negedge clk_pix);
    check({tag, ".e22_rst_out"}, 32'(rst_out), 32'd4);
    repeat (3) @(negedge clk_pix);
    check({tag, ".e25_locked"},  32'(lk),      32'd0);
    @(negedge clk_pix);
    check({tag, ".e26_rst_out"}, 32'(rst_out), 32'd0);
    check({tag, ".e26_locked"},  32'(lk),      32'd1);
    check({tag, ".e26_state"},   32'(st),      32'd3);
  endtask

  // From RUN: drop lock; the resets re-assert on the third edge counting the sampling edge.
  task automatic loss_from_run(string tag, int unsigned exp_loss, int unsigned exp_sat);
    @(negedge clk_pix);
    locked_in = 1'b0;
    repeat (2) @(negedge clk_pix);
    check({tag, ".pre_rst_out"}, 32'(rst_out), 32'd0);
    @(negedge clk_pix);
    check({tag, ".rst_out"},  32'(rst_out), 32'd7);
    check({tag, ".locked"},   32'(lk),      32'd0);
    check({tag, ".state"},    32'(st),      32'd0);
    check({tag, ".loss"},     32'(loss),    exp_loss);
    check({tag, ".sat_loss"}, 32'(loss_s),  exp_sat);
  endtask

  initial begin
    rst        = 1'b1;
    locked_in  = 1'b0;
    sw_restart = 1'b0;
    model_reset();
    #1;
    check("reset.rst_out", 32'(rst_out), 32'd7);
    check("reset.locked",  32'(lk),      32'd0);
    check("reset.loss",    32'(loss),    32'd0);
    check("reset.state",   32'(st),      32'd0);
    repeat (2) @(negedge clk_pix);
    rst      = 1'b0;
    check_en = 1'b1;

    // Short lock pulse: qualification aborts, nothing released, no loss counted
    @(negedge clk_pix);
    locked_in = 1'b1;
    repeat (10) @(negedge clk_pix);
    locked_in = 1'b0;
    repeat (6) @(negedge clk_pix);
    check("glitch.rst_out", 32'(rst_out), 32'd7);
    check("glitch.loss",    32'(loss),    32'd0);
    check("glitch.state",   32'(st),      32'd0);

    release_seq("rel1");
    loss_from_run("loss1", 1, 1);
    release_seq("rel2");

    // Software restart in RUN: immediate re-assert, count unchanged, re-qualifies with lock held
    @(negedge clk_pix);
    sw_restart = 1'b1;
    @(negedge clk_pix);
    sw_restart = 1'b0;
    check("swr.rst_out", 32'(rst_out), 32'd7);
    check("swr.locked",  32'(lk),      32'd0);
    check("swr.state",   32'(st),      32'd0);
    check("swr.loss",    32'(loss),    32'd1);
    repeat (24) @(negedge clk_pix);
    check("swr.r24_state", 32'(st), 32'd2);
    @(negedge clk_pix);
    check("swr.r25_state", 32'(st), 32'd3);

    loss_from_run("loss2", 2, 2);

    // Lock drop during RELEASE, sampled at edge 21, acted on at edge 23
    @(negedge clk_pix);
    locked_in = 1'b1;
    repeat (19) @(negedge clk_pix);
    check("relloss.e18_state", 32'(st), 32'd2);
    repeat (2) @(negedge clk_pix);
    locked_in = 1'b0;
    repeat (2) @(negedge clk_pix);
    check("relloss.e22_rst_out", 32'(rst_out), 32'd4);
    @(negedge clk_pix);
    check("relloss.e23_rst_out", 32'(rst_out), 32'd7);
    check("relloss.state",       32'(st),      32'd0);
    check("relloss.loss",        32'(loss),    32'd3);
    check("relloss.sat_loss",    32'(loss_s),  32'd3);

    // Lock drop and sw_restart on the same edge: a single counted loss
    release_seq("rel3");
    @(negedge clk_pix);
    locked_in = 1'b0;
    repeat (2) @(negedge clk_pix);
    sw_restart = 1'b1;
    @(negedge clk_pix);
    sw_restart = 1'b0;
    check("prio.rst_out",  32'(rst_out), 32'd7);
    check("prio.loss",     32'(loss),    32'd4);
    check("prio.sat_loss", 32'(loss_s),  32'd3);

    release_seq("rel4");
    loss_from_run("loss5", 5, 3);

    // Asynchronous reset between edges mid-RUN
    release_seq("rel5");
    #2;
    rst = 1'b1;
    #1;
    check("arst.rst_out", 32'(rst_out), 32'd7);
    check("arst.locked",  32'(lk),      32'd0);
    check("arst.loss",    32'(loss),    32'd0);
    check("arst.state",   32'(st),      32'd0);
    model_reset();
    locked_in = 1'b0;
    repeat (2) @(negedge clk_pix);
    rst = 1'b0;
    repeat (3) @(negedge clk_pix);
    release_seq("rel6");
    repeat (4) @(negedge clk_pix);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
